// File: rtl/sram_64x32_ctrl.sv
// Initiator-side controller for the sram_64x32 macro: valid/ready request
// issue, one-cycle-late read capture into a 2-entry response FIFO, and an
// optional zero-fill sweep of the whole macro after reset.
module sram_64x32_ctrl #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS/8-1:0]     req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  init_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_w_mask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int NBE = BITS / 8;

  typedef enum logic [1:0] {S_BOOT, S_INIT, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_inflight;
  logic [BITS-1:0]       r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_run;
  logic                  w_fire;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_credit;
  logic [BITS-1:0]       w_mask;

  assign w_run     = (r_state == S_RUN);
  assign init_done = w_run;
  assign w_fire    = req_valid & req_ready;
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_push    = r_inflight;

  // Slots already committed: buffered + the read about to land, minus the one leaving now.
  assign w_credit  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign req_ready = w_run & (w_credit < 3'd2);

  assign rsp_valid = (r_count != 2'd0);
  assign rsp_rdata = r_mem[r_rptr];

  // Expand per-byte enables to a per-bit write mask.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < NBE; i++) begin
      w_mask[i*8 +: 8] = {8{req_be[i]}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next-state and macro port drive.
  always_comb begin
    w_state_nxt = r_state;
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wd     = '0;
    sram_w_mask = '0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = (INIT_ZERO != 0) ? S_INIT : S_RUN;
      end
      S_INIT: begin
        sram_ce     = 1'b1;
        sram_we     = 1'b1;
        sram_addr   = r_cnt;
        sram_w_mask = '1;
        if (r_cnt == ADDR_WIDTH'(WORD_DEPTH - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_fire) begin
          sram_ce     = 1'b1;
          sram_we     = req_we;
          sram_addr   = req_addr;
          sram_wd     = req_wdata;
          sram_w_mask = req_we ? w_mask : '0;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Zero-fill address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
  end

  // Marks the cycle in which the macro presents read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= 1'b0;
    else        r_inflight <= w_fire & ~req_we;
  end

  // Response FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= sram_rd;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_count == 2'd2));

endmodule

// File: tb/tb_sram_64x32_ctrl.sv
// Bench for sram_64x32_ctrl: behavioural macro, reference memory and a
// response scoreboard; one task per scenario.
module tb_sram_64x32_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        sram_ce, sram_we;
  logic [5:0]  sram_addr;
  logic [31:0] sram_wd, sram_w_mask, sram_rd;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mac_mem [64];
  logic [31:0] exp_mem [64];
  logic [31:0] sb [$];
  int          last_fire_edge;
  int          first_rsp_cyc;
  logic        first_arm = 1'b0;

  sram_64x32_ctrl #(.BITS(32), .WORD_DEPTH(64), .ADDR_WIDTH(6), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wd(sram_wd), .sram_w_mask(sram_w_mask), .sram_rd(sram_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro: masked write, registered read, no reset.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mac_mem[sram_addr] <= (mac_mem[sram_addr] & ~sram_w_mask) | (sram_wd & sram_w_mask);
      else         sram_rd <= mac_mem[sram_addr];
    end
  end

  // Scoreboard: every accepted response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got=%h expected=none", rsp_rdata);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (rsp_rdata !== e) begin
          errors++;
          $display("FAIL rsp_data got=%h expected=%h", rsp_rdata, e);
        end
      end
    end
    if (first_arm && rsp_valid) begin
      first_rsp_cyc = cyc;
      first_arm = 1'b0;
    end
  end

  // One request, held until accepted; reads push their expectation on acceptance.
  task automatic do_req(input logic we, input logic [5:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int waits);
    waits = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    forever begin
      @(negedge clk);
      if (req_ready) begin
        last_fire_edge = cyc + 1;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) exp_mem[a][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          sb.push_back(exp_mem[a]);
        end
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waits++;
      if (waits > 200) begin
        checks++; errors++;
        $display("FAIL req_timeout addr=%0d got=ready_low expected=accept", a);
        break;
      end
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL init_timeout got=%b expected=1", init_done);
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({rsp_valid, rsp_rdata, req_ready, init_done, sram_ce, sram_we, sram_addr, sram_wd, sram_w_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%h%b%b%b%b%h%h%h expected=all_zero",
               rsp_valid, rsp_rdata, req_ready, init_done, sram_ce, sram_we, sram_addr, sram_wd, sram_w_mask);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!sram_ce && n < 5) begin @(negedge clk); n++; end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({sram_ce, sram_we, sram_addr, sram_w_mask, sram_wd, init_done, req_ready} !==
          {1'b1, 1'b1, 6'(i), 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL init_sweep_%0d got=ce%b we%b a%0d m%h d%h done%b rdy%b expected=ce1 we1 a%0d mffffffff d0 done0 rdy0",
                 i, sram_ce, sram_we, sram_addr, sram_w_mask, sram_wd, init_done, req_ready, i);
      end
      @(negedge clk);
    end
    checks++;
    if ({init_done, sram_ce} !== 2'b10) begin
      errors++;
      $display("FAIL init_end got=done%b ce%b expected=done1 ce0", init_done, sram_ce);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
  endtask

  task automatic test_zero_read();
    int w;
    do_req(1'b0, 6'd17, '0, '0, w);
    idle();
    wait_drain();
  endtask

  task automatic test_byte_mask();
    int w;
    do_req(1'b1, 6'd5, 32'hDEAD_BEEF, 4'b1111, w);
    do_req(1'b1, 6'd5, 32'h0000_0000, 4'b0010, w);
    do_req(1'b0, 6'd5, '0, '0, w);
    idle();
    wait_drain();
  endtask

  task automatic preload();
    int w;
    for (int i = 0; i < 8; i++) do_req(1'b1, 6'(i), 32'(i * 3), 4'hF, w);
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w, fire0;
    rsp_ready = 1'b1;
    first_arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 6'(i), '0, '0, w);
      if (i == 0) fire0 = last_fire_edge;
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL b2b_ready_%0d got=%0d waits expected=0", i, w);
      end
    end
    idle();
    wait_drain();
    checks++;
    if (first_rsp_cyc != fire0 + 1) begin
      errors++;
      $display("FAIL b2b_latency got=%0d expected=%0d", first_rsp_cyc - fire0 + 1, 2);
    end
  endtask

  task automatic test_stall();
    int idx, w;
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(idx);
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(exp_mem[idx]);
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL stall_accepted got=%0d expected=2", idx);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 32'd0}) begin
        errors++;
        $display("FAIL stall_hold got=rdy%b v%b d%h expected=rdy0 v1 d00000000", req_ready, rsp_valid, rsp_rdata);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    while (idx < 8) begin
      do_req(1'b0, 6'(idx), '0, '0, w);
      idx++;
    end
    idle();
    wait_drain();
  endtask

  task automatic test_raw();
    int w;
    rsp_ready = 1'b1;
    do_req(1'b1, 6'd9, 32'h1234_5678, 4'hF, w);
    do_req(1'b0, 6'd9, '0, '0, w);
    idle();
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    int w, seen;
    rsp_ready = 1'b0;
    do_req(1'b0, 6'd2, '0, '0, w);
    do_req(1'b0, 6'd3, '0, '0, w);
    idle();
    // One response buffered, one read on the macro's output this cycle.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, sram_ce, req_ready, init_done} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs got=v%b ce%b rdy%b done%b expected=0000", rsp_valid, sram_ce, req_ready, init_done);
    end
    sb.delete();
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_stale got=%0d responses expected=0", seen);
    end
    @(posedge clk); #1;
    do_req(1'b0, 6'd3, '0, '0, w);
    idle();
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mac_mem[i] = 32'hA5A5_0000 | 32'(i);
      exp_mem[i] = '0;
    end
    sram_rd = 32'hBAD0_BAD0;
    test_reset();
    test_zero_read();
    test_byte_mask();
    preload();
    test_back_to_back();
    test_stall();
    test_raw();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
